inst_loader: RTL and testbench
==============================

# inst_loader

Boot-time program loader: the write side of the CPU's instruction RAM. It accepts a byte stream over a valid/ready handshake, packs the bytes big-endian into 32-bit instruction words and writes them to consecutive instruction-RAM addresses. It holds the pipeline in reset until the terminating end-of-program word has been written, then releases it. It sits between the external program source and the instruction RAM / the CPU's RESET input.

## Interface
- ADDR_W, 9, instruction-RAM word-address width; depth = 2**ADDR_W words.
- END_WORD, 32'hFFFF_FFFF, end-of-program marker; it is written to RAM (the CPU halts on it), then loading ends.

- CLOCK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- in_valid  in  1  in_byte holds a valid byte.
- in_byte  in  8  stream byte; the first byte of each word is bits [31:24].
- in_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  instruction-RAM write strobe, one cycle per word.
- imem_addr  out  ADDR_W  word address (byte address >> 2).
- imem_wdata  out  32  assembled instruction word.
- cpu_reset  out  1  drives the CPU's RESET input; high while loading.
- done  out  1  load completed successfully; sticky until RESET.
- error  out  1  load failed; sticky until RESET.
- word_count  out  ADDR_W+1  number of words written so far.

## Operation
- **States:** LOAD, WRITE, DONE, ERR; `LOADER_CHECKSUM_EN` adds CHECK.
- **Reset values:** state=LOAD, byte_idx=0, addr=0, word_count=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, done=0, error=0. in_ready=1 from the first cycle after reset.
- **LOAD:**
  - in_ready=1.
  - A byte is accepted when in_valid && in_ready: shift it into the word register and increment byte_idx (2-bit, wraps).
  - On the byte accepted with byte_idx==3, go to WRITE.
- **WRITE:**
  - in_ready=0; imem_we=1; imem_addr=addr; imem_wdata=the assembled word.
  - Next state, checked in this priority:
    1. word==END_WORD → DONE, or CHECK when the macro is defined.
    2. addr==2**ADDR_W−1 → ERR (RAM full, no end marker).
    3. Otherwise addr+1, back to LOAD.
  - word_count increments on every WRITE cycle, including the end-marker write.
- **DONE:** in_ready=0, cpu_reset=0, done=1. Further input is ignored (never accepted).
- **ERR:** in_ready=0, cpu_reset=1, error=1. Only RESET leaves ERR.
- **End marker at the last address:** if the word is END_WORD and addr is 2**ADDR_W−1, the load ends in DONE, not ERR.
- **Reset mid-load:** everything returns to its reset values. A partial word is discarded. RAM contents are left untouched; the new load overwrites them from address 0.
- **Stalled input:** in_valid low in LOAD is a stall with no timeout; the partial word is held.

## Timing
- The 4th byte is accepted in cycle N; imem_we=1 in cycle N+1; in_ready returns high in cycle N+2. Minimum throughput is 5 cycles per word.
- For the end-marker word, cpu_reset falls (and done rises) in cycle N+2. This is the CPU's first cycle out of reset.
- imem_* are registered outputs. imem_addr and imem_wdata are stable during the imem_we cycle.
- done and error are never both 1.

## Configuration
- **`LOADER_CHECKSUM_EN` defined:**
  - After the end-marker write, the FSM enters CHECK with in_ready=1.
  - It accepts exactly one byte, which must equal the XOR of every program byte, including the END_WORD bytes.
  - Equal → DONE; not equal → ERR.
  - The XOR accumulator clears on RESET.
- **Macro undefined:** no CHECK state and no accumulator; the end-marker write goes directly to DONE.

## Structure
- Package `loader_pkg` holds:
  - the state enum typedef `loader_state_t`;
  - the default END_WORD constant;
  - the byte-count width constant (2).
- One sub-module, `word_packer`, does byte_idx counting, shift assembly and the word-complete pulse. The FSM, address counter and checksum stay in `inst_loader`.

## Test plan
- **Single-word program:** stream FF FF FF FF → one write at addr 0 with data 32'hFFFF_FFFF; cpu_reset falls 2 cycles after the 4th byte; done=1; word_count=1.
- **Two-word program:** stream 20 08 00 05, FF FF FF FF with in_valid toggling every other cycle. Required: writes addr0=32'h2008_0005 and addr1=32'hFFFF_FFFF; in_ready=0 during each write cycle.
- **Overflow:** with ADDR_W=2, send four non-end words → ERR after the 4th write; error=1; cpu_reset stays 1; a 5th word is never accepted.
- **Mid-word reset:** send 3 bytes, pulse RESET, then FF FF FF FF → a single write at addr 0 with 32'hFFFF_FFFF; the discarded bytes do not appear in any write.
- **Checksum, `LOADER_CHECKSUM_EN`:** load 20 08 00 05 FF FF FF FF, then a checksum byte 0x2D → DONE. Repeat with a checksum byte 0x00 → ERR, error=1.
- **Post-DONE input:** in_valid held at 1 with random bytes after done → in_ready stays 0, no further imem_we, word_count unchanged.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
// The CHECK state exists only when LOADER_CHECKSUM_EN is defined.
package loader_pkg;

    localparam logic [31:0] END_WORD_DEFAULT = 32'hFFFF_FFFF;
    localparam int unsigned BYTE_IDX_W       = 2;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        StLoad,
        StWrite,
        StDone,
        StErr,
        StCheck
    } loader_state_t;
`else
    typedef enum logic [1:0] {
        StLoad,
        StWrite,
        StDone,
        StErr
    } loader_state_t;
`endif

endpackage

// File: rtl/inst_loader_if.sv
// Byte-stream input, instruction-RAM write port and status outputs of the loader.
// Signal set is identical with or without LOADER_CHECKSUM_EN.
interface inst_loader_if #(
    parameter int unsigned ADDR_W = 9
);
    logic              in_valid;
    logic [7:0]        in_byte;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   word_count;

    // Loader side.
    modport slave (
        input  in_valid,
        input  in_byte,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata,
        output cpu_reset,
        output done,
        output error,
        output word_count
    );

    // Program source / observer side.
    modport master (
        output in_valid,
        output in_byte,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata,
        input  cpu_reset,
        input  done,
        input  error,
        input  word_count
    );
endinterface

// File: rtl/word_packer.sv
// Packs accepted bytes big-endian into 32-bit words and flags the byte that completes a word.
// Behaviour is the same with or without LOADER_CHECKSUM_EN.
module word_packer
    import loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_done_o
);
    logic [BYTE_IDX_W-1:0] byte_idx_d, byte_idx_q;
    // Only three bytes need storing; the fourth arrives on the completing cycle.
    logic [23:0]           word_d, word_q;

    assign word_o      = {word_q, byte_i};
    assign word_done_o = accept_i && (byte_idx_q == '1);

    always_comb begin
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        if (accept_i) begin
            byte_idx_d = byte_idx_q + BYTE_IDX_W'(1);
            word_d     = word_o[23:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            byte_idx_q <= '0;
            word_q     <= '0;
        end else begin
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
        end
    end

endmodule

// File: rtl/inst_loader.sv
// Boot-time program loader: packs a byte stream into instruction-RAM writes and holds the CPU
// in reset until the end-of-program word is written. LOADER_CHECKSUM_EN adds an XOR check byte.
module inst_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W   = 9,
    parameter logic [31:0] END_WORD = END_WORD_DEFAULT
) (
    input logic          CLOCK,
    input logic          RESET,
    inst_loader_if.slave bus
);
    localparam logic [ADDR_W-1:0] AddrMax = '1;

    loader_state_t     state_d, state_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [ADDR_W:0]   word_count_d, word_count_q;
    logic              imem_we_d, imem_we_q;
    logic [ADDR_W-1:0] imem_addr_d, imem_addr_q;
    logic [31:0]       imem_wdata_d, imem_wdata_q;

    logic              in_ready;
    logic              cpu_reset;
    logic              done;
    logic              error;
    logic              pack_accept;
    logic [31:0]       pack_word;
    logic              pack_done;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_d, csum_q;
`endif

    word_packer u_word_packer (
        .clk_i       (CLOCK),
        .rst_i       (RESET),
        .accept_i    (pack_accept),
        .byte_i      (bus.in_byte),
        .word_o      (pack_word),
        .word_done_o (pack_done)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        word_count_d = word_count_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        in_ready     = 1'b0;
        cpu_reset    = 1'b1;
        done         = 1'b0;
        error        = 1'b0;
        pack_accept  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum_d       = csum_q;
`endif

        case (state_q)
            StLoad: begin
                in_ready    = 1'b1;
                pack_accept = bus.in_valid;
`ifdef LOADER_CHECKSUM_EN
                if (pack_accept) begin
                    csum_d = csum_q ^ bus.in_byte;
                end
`endif
                // Write strobe, address and data are registered so they launch together.
                if (pack_done) begin
                    state_d      = StWrite;
                    imem_we_d    = 1'b1;
                    imem_addr_d  = addr_q;
                    imem_wdata_d = pack_word;
                end
            end
            StWrite: begin
                word_count_d = word_count_q + (ADDR_W + 1)'(1);
                if (imem_wdata_q == END_WORD) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = StCheck;
`else
                    state_d = StDone;
`endif
                end else if (addr_q == AddrMax) begin
                    state_d = StErr;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = StLoad;
                end
            end
            StDone: begin
                cpu_reset = 1'b0;
                done      = 1'b1;
            end
            StErr: begin
                error = 1'b1;
            end
`ifdef LOADER_CHECKSUM_EN
            StCheck: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_d = (bus.in_byte == csum_q) ? StDone : StErr;
                end
            end
`endif
            default: begin
                state_d = StErr;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q      <= StLoad;
            addr_q       <= '0;
            word_count_q <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            word_count_q <= word_count_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.cpu_reset  = cpu_reset;
    assign bus.done       = done;
    assign bus.error      = error;
    assign bus.word_count = word_count_q;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader with a 4-word RAM; writes are matched against a scoreboard.
// Covers both builds: with LOADER_CHECKSUM_EN a computed XOR byte follows each finished program.
module tb_inst_loader;
    localparam int unsigned AW = 2;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    typedef struct {
        int                n;
        logic [3:0][31:0]  w;
        bit                gap;
        bit                exp_done;
        bit                exp_err;
        int                exp_count;
    } rec_t;

    logic CLOCK;
    logic RESET;

    inst_loader_if #(.ADDR_W(AW)) bus ();

    inst_loader #(.ADDR_W(AW)) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    int         tests;
    int         fails;
    wr_t        exp_q[$];
    logic [7:0] model_xor;
    int         model_addr;
    rec_t       recs[5];

    function automatic rec_t mk(input int n, input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3, input bit gap,
                                input bit d, input bit e, input int cnt);
        rec_t r;
        r.n = n;
        r.w[0] = w0;
        r.w[1] = w1;
        r.w[2] = w2;
        r.w[3] = w3;
        r.gap = gap;
        r.exp_done = d;
        r.exp_err = e;
        r.exp_count = cnt;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock step; outputs are sampled 1ns after the edge and writes are scoreboarded here.
    task automatic tick();
        wr_t e;
        @(posedge CLOCK);
        #1;
        if (bus.imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(bus.imem_addr), 32'hDEAD);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.imem_addr), 32'(e.addr));
                check("wr_data", bus.imem_wdata, e.data);
                check("wr_ready_low", 32'(bus.in_ready), 32'd0);
            end
        end
        if (bus.done === 1'b1 && bus.error === 1'b1) begin
            check("done_err_excl", 32'(bus.error), 32'd0);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap, input int budget, output bit ok);
        logic rdy;
        ok = 1'b0;
        if (gap) begin
            bus.in_valid = 1'b0;
            tick();
        end
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        for (int i = 0; i < budget && !ok; i++) begin
            rdy = bus.in_ready;
            tick();
            ok = rdy;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] word, input bit gap);
        bit         ok;
        logic [7:0] b;
        exp_q.push_back('{addr: AW'(model_addr), data: word});
        model_addr++;
        for (int k = 0; k < 4; k++) begin
            b = word[31-8*k -: 8];
            model_xor ^= b;
            send_byte(b, gap, 12, ok);
            check("byte_accept", 32'(ok), 32'd1);
        end
    endtask

    task automatic finish_program();
`ifdef LOADER_CHECKSUM_EN
        bit ok;
        send_byte(model_xor, 1'b0, 8, ok);
        check("csum_accept", 32'(ok), 32'd1);
`endif
        repeat (3) tick();
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        exp_q.delete();
        model_xor  = 8'h00;
        model_addr = 0;
    endtask

    task automatic check_reset_vals();
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_imem_we", 32'(bus.imem_we), 32'd0);
        check("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
        check("rst_imem_wdata", bus.imem_wdata, 32'd0);
        check("rst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_error", 32'(bus.error), 32'd0);
        check("rst_word_count", 32'(bus.word_count), 32'd0);
    endtask

    initial begin
        bit ok;
        tests = 0;
        fails = 0;
        RESET = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;
        model_xor  = 8'h00;
        model_addr = 0;

        recs[0] = mk(1, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1);
        recs[1] = mk(2, 32'h2008_0005, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 2);
        recs[2] = mk(4, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
                     1'b0, 1'b0, 1'b1, 4);
        recs[3] = mk(4, 32'h0102_0304, 32'hA5A5_A5A5, 32'h0000_0000, 32'hFFFF_FFFF,
                     1'b1, 1'b1, 1'b0, 4);
        recs[4] = mk(3, 32'hFFFF_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0,
                     1'b0, 1'b1, 1'b0, 3);

        do_reset();
        check_reset_vals();

        // Table-driven programs: writes, final status, and no byte accepted afterwards.
        for (int r = 0; r < 5; r++) begin
            do_reset();
            for (int k = 0; k < recs[r].n; k++) send_word(recs[r].w[k], recs[r].gap);
            if (recs[r].exp_done) finish_program();
            else repeat (3) tick();
            check("prog_done", 32'(bus.done), 32'(recs[r].exp_done));
            check("prog_error", 32'(bus.error), 32'(recs[r].exp_err));
            check("prog_cpu_reset", 32'(bus.cpu_reset), 32'(!recs[r].exp_done));
            check("prog_word_count", 32'(bus.word_count), 32'(recs[r].exp_count));
            check("prog_ready_low", 32'(bus.in_ready), 32'd0);
            send_byte(8'h5A, 1'b0, 6, ok);
            check("extra_byte_refused", 32'(ok), 32'd0);
            check("extra_word_count", 32'(bus.word_count), 32'(recs[r].exp_count));
            check("prog_queue_empty", 32'(exp_q.size()), 32'd0);
        end

        // Cycle-exact timing of the end-marker word, then input held after completion.
        do_reset();
        exp_q.push_back('{addr: AW'(0), data: 32'hFFFF_FFFF});
        for (int k = 0; k < 3; k++) begin
            send_byte(8'hFF, 1'b0, 6, ok);
            check("t_accept", 32'(ok), 32'd1);
        end
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'hFF;
        check("t_ready_n", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("t_we_n1", 32'(bus.imem_we), 32'd1);
        check("t_cpu_reset_n1", 32'(bus.cpu_reset), 32'd1);
        tick();
        check("t_we_n2", 32'(bus.imem_we), 32'd0);
        check("t_word_count_n2", 32'(bus.word_count), 32'd1);
`ifdef LOADER_CHECKSUM_EN
        check("t_check_ready", 32'(bus.in_ready), 32'd1);
        check("t_check_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        send_byte(8'h00, 1'b0, 4, ok);
        check("t_csum_accept", 32'(ok), 32'd1);
        check("t_csum_done", 32'(bus.done), 32'd1);
`else
        check("t_cpu_reset_n2", 32'(bus.cpu_reset), 32'd0);
        check("t_done_n2", 32'(bus.done), 32'd1);
        check("t_ready_n2", 32'(bus.in_ready), 32'd0);
`endif
        bus.in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.in_byte = 8'($urandom);
            check("post_done_ready", 32'(bus.in_ready), 32'd0);
            tick();
        end
        bus.in_valid = 1'b0;
        check("post_done_count", 32'(bus.word_count), 32'd1);
        check("post_done_done", 32'(bus.done), 32'd1);
        check("post_done_queue", 32'(exp_q.size()), 32'd0);

        // Reset after a partial word: the three stray bytes must never reach RAM.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            send_byte(8'h12 + 8'(k), 1'b0, 6, ok);
            check("mid_accept", 32'(ok), 32'd1);
        end
        do_reset();
        check_reset_vals();
        send_word(32'hFFFF_FFFF, 1'b0);
        finish_program();
        check("mid_done", 32'(bus.done), 32'd1);
        check("mid_word_count", 32'(bus.word_count), 32'd1);
        check("mid_queue_empty", 32'(exp_q.size()), 32'd0);

`ifdef LOADER_CHECKSUM_EN
        // Wrong checksum byte ends in the error state.
        do_reset();
        send_word(32'h2008_0005, 1'b0);
        send_word(32'hFFFF_FFFF, 1'b0);
        send_byte(8'h00, 1'b0, 8, ok);
        check("bad_csum_accept", 32'(ok), 32'd1);
        repeat (2) tick();
        check("bad_csum_error", 32'(bus.error), 32'd1);
        check("bad_csum_done", 32'(bus.done), 32'd0);
        check("bad_csum_cpu_reset", 32'(bus.cpu_reset), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
